huff_decode_stream: RTL and testbench

- Serial Huffman decoder that turns a compressed bitstream back into the 4-bit digit stream (symbols 0..9).
- Reloads the per-symbol code table (code plus length) produced by the encoder side.
- Emits one decoded nibble per matched codeword, then a 4'hF terminator, which matches the stop convention of the digit-counting front end.
- Sits at the receive/decompress end of the Huffman datapath; its output can feed the counting front end directly for loopback checks.

---
 rtl/huff_decode_stream.sv | 180 ++++++++++++++++++
 tb/tb_huff_decode_stream.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huff_decode_stream.sv
// huff_decode_stream: serial Huffman decoder turning a compressed bitstream back
// into 4-bit digit symbols (0..9), followed by a single 4'hF terminator strobe.
// Optional capture buffer (All_out) is built when HUFF_DECODE_BUF_EN is defined.
module huff_decode_stream #(
  parameter int unsigned MAX_LEN = 9
) (
  input  logic          Clk_in,
  input  logic          nRst,
  input  logic          Start,
  input  logic [8:0]    Sym_total,
  input  logic [89:0]   Code_tab,
  input  logic [39:0]   Len_tab,
  input  logic          Bit_in,
  input  logic          Bit_valid,
  output logic          Bit_ready,
  output logic [3:0]    Data_out,
  output logic          Data_valid,
  output logic          Err,
  output logic          Fin
`ifdef HUFF_DECODE_BUF_EN
  ,
  output logic [1023:0] All_out
`endif
);

  localparam int unsigned NSYM = 10;
  localparam int unsigned CW   = 9;   // code field width per symbol
  localparam int unsigned LW   = 4;   // length field width per symbol
  localparam int unsigned DW   = 4;   // output symbol width
  localparam int unsigned CNTW = 9;   // symbol counter width (256 -> 9'h100)

  typedef enum logic [2:0] {IDLE, RUN, TERM, DONE, ERR} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     acc, acc_n;
  logic [LW-1:0]     len, len_n;
  logic [CNTW-1:0]   cnt, cnt_n;
  logic [CNTW-1:0]   total, total_n;
  logic [DW-1:0]     dout_n;
  logic              dvalid_n;
  logic              err_n;
  logic              fin_n;
  logic              ready_n;

  logic [CW-1:0]     sh_acc;
  logic [LW-1:0]     sh_len;
  logic [CW-1:0]     code_mask;
  logic              hit;
  logic [DW-1:0]     hit_sym;
  logic              take;
  logic              sym_take;
  logic              start_go;

  // Candidate accumulator/length after shifting in the current bit
  always_comb begin
    sh_acc    = {acc[CW-2:0], Bit_in};
    sh_len    = len + LW'(1);
    code_mask = (CW'(1) << sh_len) - CW'(1);
  end

  // Table lookup: scan high to low so the lowest matching index wins
  always_comb begin
    hit     = 1'b0;
    hit_sym = '0;
    for (int s = int'(NSYM) - 1; s >= 0; s--) begin
      if ((Len_tab[LW*s +: LW] == sh_len) &&
          ((Code_tab[CW*s +: CW] & code_mask) == sh_acc)) begin
        hit     = 1'b1;
        hit_sym = DW'(s);
      end
    end
  end

  // Next-state and registered-output values
  always_comb begin
    state_n  = state;
    acc_n    = acc;
    len_n    = len;
    cnt_n    = cnt;
    total_n  = total;
    dout_n   = Data_out;
    dvalid_n = 1'b0;
    err_n    = Err;
    fin_n    = Fin;
    take     = 1'b0;
    sym_take = 1'b0;
    start_go = 1'b0;

    case (state)
      IDLE, DONE, ERR: begin
        if (Start) begin
          start_go = 1'b1;
          state_n  = RUN;
          acc_n    = '0;
          len_n    = '0;
          cnt_n    = '0;
          err_n    = 1'b0;
          fin_n    = 1'b0;
          total_n  = (Sym_total == '0) ? CNTW'(256) : Sym_total;
        end
      end
      RUN: begin
        take = Bit_valid && Bit_ready;
        if (take) begin
          if (hit) begin
            sym_take = 1'b1;
            dout_n   = hit_sym;
            dvalid_n = 1'b1;
            acc_n    = '0;
            len_n    = '0;
            cnt_n    = cnt + CNTW'(1);
            if ((cnt + CNTW'(1)) == total) begin
              state_n = TERM;
            end
          end else if (sh_len == LW'(MAX_LEN)) begin
            state_n = ERR;
            err_n   = 1'b1;
            acc_n   = '0;
            len_n   = '0;
          end else begin
            acc_n = sh_acc;
            len_n = sh_len;
          end
        end
      end
      TERM: begin
        dout_n   = 4'hF;
        dvalid_n = 1'b1;
        fin_n    = 1'b1;
        state_n  = DONE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    ready_n = (state_n == RUN);
  end

  // State and output registers
  always_ff @(posedge Clk_in or negedge nRst) begin
    if (!nRst) begin
      state      <= IDLE;
      acc        <= '0;
      len        <= '0;
      cnt        <= '0;
      total      <= '0;
      Data_out   <= '0;
      Data_valid <= 1'b0;
      Err        <= 1'b0;
      Fin        <= 1'b0;
      Bit_ready  <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      len        <= len_n;
      cnt        <= cnt_n;
      total      <= total_n;
      Data_out   <= dout_n;
      Data_valid <= dvalid_n;
      Err        <= err_n;
      Fin        <= fin_n;
      Bit_ready  <= ready_n;
    end
  end

`ifdef HUFF_DECODE_BUF_EN
  // Capture buffer: symbol k lands in nibble k; terminator is not stored
  always_ff @(posedge Clk_in or negedge nRst) begin
    if (!nRst) begin
      All_out <= '0;
    end else if (start_go) begin
      All_out <= '0;
    end else if (sym_take) begin
      All_out[DW*cnt[7:0] +: DW] <= hit_sym;
    end
  end
`endif

endmodule

// File: tb/tb_huff_decode_stream.sv
// tb_huff_decode_stream: randomized/directed bench with a stream-level reference
// decoder. Handles builds with or without HUFF_DECODE_BUF_EN.
module tb_huff_decode_stream;

  logic          Clk_in = 1'b0;
  logic          nRst = 1'b0;
  logic          Start = 1'b0;
  logic [8:0]    Sym_total = '0;
  logic [89:0]   Code_tab = '0;
  logic [39:0]   Len_tab = '0;
  logic          Bit_in = 1'b0;
  logic          Bit_valid = 1'b0;
  logic          Bit_ready;
  logic [3:0]    Data_out;
  logic          Data_valid;
  logic          Err;
  logic          Fin;
`ifdef HUFF_DECODE_BUF_EN
  logic [1023:0] All_out;
`endif

  huff_decode_stream dut (
    .Clk_in     (Clk_in),
    .nRst       (nRst),
    .Start      (Start),
    .Sym_total  (Sym_total),
    .Code_tab   (Code_tab),
    .Len_tab    (Len_tab),
    .Bit_in     (Bit_in),
    .Bit_valid  (Bit_valid),
    .Bit_ready  (Bit_ready),
    .Data_out   (Data_out),
    .Data_valid (Data_valid),
    .Err        (Err),
    .Fin        (Fin)
`ifdef HUFF_DECODE_BUF_EN
    ,
    .All_out    (All_out)
`endif
  );

  always #5 Clk_in = ~Clk_in;

  int n_assert = 0;
  int n_fail   = 0;

  int code_t[10];
  int len_t[10];
  int bits[$];
  int exp_sym[$];
  int exp_idx[$];
  bit exp_err;
  int err_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_tables();
    for (int s = 0; s < 10; s++) begin
      code_t[s] = 0;
      len_t[s]  = 0;
    end
    bits.delete();
  endtask

  task automatic load_tables();
    for (int s = 0; s < 10; s++) begin
      Code_tab[9*s +: 9] = 9'(code_t[s]);
      Len_tab[4*s +: 4]  = 4'(len_t[s]);
    end
  endtask

  // Append symbol s's codeword, MSB first
  task automatic push_sym(input int s);
    for (int b = len_t[s] - 1; b >= 0; b--) bits.push_back((code_t[s] >> b) & 1);
  endtask

  // Reference: prefix-decode the whole stream up front, lowest index first
  task automatic model(input int total_eff);
    int cur;
    int l;
    int hit;
    cur = 0;
    l = 0;
    exp_sym.delete();
    exp_idx.delete();
    exp_err = 1'b0;
    err_idx = -1;
    for (int i = 0; i < bits.size(); i++) begin
      cur = cur * 2 + bits[i];
      l++;
      hit = -1;
      for (int s = 0; s < 10; s++)
        if (hit < 0 && len_t[s] == l && (code_t[s] % (1 << l)) == cur) hit = s;
      if (hit >= 0) begin
        exp_sym.push_back(hit);
        exp_idx.push_back(i);
        cur = 0;
        l = 0;
        if (exp_sym.size() == total_eff) break;
      end else if (l == 9) begin
        exp_err = 1'b1;
        err_idx = i;
        break;
      end
    end
  endtask

  // vmode: 0 = valid always, 1 = toggling, 2 = random
  task automatic run_case(input string tag, input int vmode, input int total_in);
    int tot_eff;
    int bi;
    int sj;
    bit term_p;
    bit stop;
    bit acc;
    bit v;
    tot_eff = (total_in == 0) ? 256 : total_in;
    load_tables();
    Sym_total = 9'(total_in);
    model(tot_eff);
    @(negedge Clk_in);
    Start = 1'b1;
    @(negedge Clk_in);
    Start = 1'b0;
    check({tag, " start rdy"}, Bit_ready, 1);
    check({tag, " start err"}, Err, 0);
    check({tag, " start fin"}, Fin, 0);
    check({tag, " start dv"}, Data_valid, 0);
    bi = 0;
    sj = 0;
    term_p = 1'b0;
    stop = 1'b0;
    for (int cyc = 0; cyc < 6000 && !stop; cyc++) begin
      if (vmode == 0) v = 1'b1;
      else if (vmode == 1) v = (cyc % 2 == 0);
      else v = 1'($urandom_range(0, 1));
      if (bi >= bits.size()) v = 1'b0;
      Bit_valid = v;
      Bit_in = v ? 1'(bits[bi]) : 1'b0;
      acc = v && Bit_ready;
      @(negedge Clk_in);
      if (term_p) begin
        check({tag, " term dv"}, Data_valid, 1);
        check({tag, " term data"}, Data_out, 4'hF);
        check({tag, " fin"}, Fin, 1);
        check({tag, " done rdy"}, Bit_ready, 0);
        stop = 1'b1;
      end else if (acc) begin
        if (sj < exp_sym.size() && exp_idx[sj] == bi) begin
          check({tag, " sym dv"}, Data_valid, 1);
          check({tag, " sym data"}, Data_out, exp_sym[sj]);
          sj++;
          term_p = (sj == tot_eff);
          check({tag, " sym rdy"}, Bit_ready, !term_p);
        end else if (exp_err && bi == err_idx) begin
          check({tag, " err dv"}, Data_valid, 0);
          check({tag, " err flag"}, Err, 1);
          check({tag, " err rdy"}, Bit_ready, 0);
          stop = 1'b1;
        end else begin
          check({tag, " mid dv"}, Data_valid, 0);
          check({tag, " mid rdy"}, Bit_ready, 1);
        end
        bi++;
      end else begin
        check({tag, " idle dv"}, Data_valid, 0);
      end
    end
    Bit_valid = 1'b0;
    check({tag, " completed"}, stop, 1);
    check({tag, " strobes"}, sj, exp_err ? exp_sym.size() : tot_eff);
    @(negedge Clk_in);
    check({tag, " hold dv"}, Data_valid, 0);
    check({tag, " hold err"}, Err, exp_err);
    check({tag, " hold fin"}, Fin, !exp_err);
    check({tag, " hold rdy"}, Bit_ready, 0);
`ifdef HUFF_DECODE_BUF_EN
    for (int k = 0; k < exp_sym.size(); k++)
      check({tag, " buf"}, All_out[4*k +: 4], exp_sym[k]);
`endif
  endtask

  task automatic table_a();
    clear_tables();
    code_t[0] = 0; len_t[0] = 1;
    code_t[1] = 2; len_t[1] = 2;
    code_t[2] = 3; len_t[2] = 2;
  endtask

  // Canonical prefix code with lengths 2,2,3,3,4,4,5,5,5,5
  task automatic table_canon();
    clear_tables();
    code_t[0] = 0;  len_t[0] = 2;
    code_t[1] = 1;  len_t[1] = 2;
    code_t[2] = 4;  len_t[2] = 3;
    code_t[3] = 5;  len_t[3] = 3;
    code_t[4] = 12; len_t[4] = 4;
    code_t[5] = 13; len_t[5] = 4;
    code_t[6] = 28; len_t[6] = 5;
    code_t[7] = 29; len_t[7] = 5;
    code_t[8] = 30; len_t[8] = 5;
    code_t[9] = 31; len_t[9] = 5;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset values
    #3;
    check("rst data", Data_out, 0);
    check("rst dv", Data_valid, 0);
    check("rst err", Err, 0);
    check("rst fin", Fin, 0);
    check("rst rdy", Bit_ready, 0);
    @(negedge Clk_in);
    nRst = 1'b1;

    // Basic three-symbol stream, continuous and gapped
    table_a();
    bits = '{0, 1, 0, 1, 1};
    run_case("basic", 0, 3);
    run_case("toggle", 1, 3);

    // Duplicate codes: lowest index must win
    clear_tables();
    code_t[0] = 0; len_t[0] = 1;
    code_t[3] = 1; len_t[3] = 1;
    code_t[5] = 1; len_t[5] = 1;
    bits = '{1, 0, 1};
    run_case("prio", 2, 3);

    // Full 256-symbol run with fixed 4-bit codes
    clear_tables();
    for (int s = 0; s < 10; s++) begin
      code_t[s] = s;
      len_t[s]  = 4;
    end
    for (int k = 0; k < 256; k++) push_sym(k % 10);
    run_case("full256", 0, 256);
`ifdef HUFF_DECODE_BUF_EN
    check("buf first", All_out[3:0], 0);
    check("buf ninth", All_out[39:36], 9);
    check("buf last", All_out[1023:1020], 5);
`endif

    // No codeword within 9 bits -> error, then recovery via Start
    clear_tables();
    code_t[0] = 0; len_t[0] = 1;
    code_t[1] = 2; len_t[1] = 2;
    for (int i = 0; i < 12; i++) bits.push_back(1);
    run_case("error", 2, 5);
    table_a();
    bits = '{1, 1, 0, 1, 0, 0};
    run_case("recover", 2, 4);

    // Reset mid-run after two symbols
    table_a();
    load_tables();
    Sym_total = 9'd3;
    @(negedge Clk_in);
    Start = 1'b1;
    @(negedge Clk_in);
    Start = 1'b0;
    Bit_valid = 1'b1;
    Bit_in = 1'b0;
    @(negedge Clk_in);
    Bit_in = 1'b1;
    @(negedge Clk_in);
    Bit_in = 1'b0;
    @(negedge Clk_in);
    Bit_valid = 1'b0;
    check("pre-rst dv", Data_valid, 1);
    check("pre-rst data", Data_out, 1);
    #2;
    nRst = 1'b0;
    #1;
    check("midrst data", Data_out, 0);
    check("midrst dv", Data_valid, 0);
    check("midrst rdy", Bit_ready, 0);
    check("midrst fin", Fin, 0);
    check("midrst err", Err, 0);
    @(negedge Clk_in);
    nRst = 1'b1;
    bits = '{0, 1, 0, 1, 1};
    run_case("after-rst", 0, 3);

    // Sym_total = 0 means 256
    clear_tables();
    code_t[7] = 0; len_t[7] = 1;
    for (int i = 0; i < 256; i++) bits.push_back(0);
    run_case("total0", 0, 0);

    // Randomized streams over a canonical code
    for (int r = 0; r < 4; r++) begin
      table_canon();
      n = int'($urandom_range(1, 40));
      for (int k = 0; k < n; k++) push_sym(int'($urandom_range(0, 9)));
      run_case("random", 2, n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
